serial_word_receiver: RTL and testbench

//   Serial-to-parallel receiver. Pairs with the parallel-load/serial-out shift transmitter.

---
 rtl/serial_word_receiver.sv | 110 +++++++++++
 tb/tb_serial_word_receiver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver: assembles WIDTH-bit words from strobed serial bits
// and presents them on a holding register with a Valid/Ack handshake and sticky overrun.
module serial_word_receiver #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in,
  input  logic             i_shift,
  input  logic             i_start,
  input  logic             i_ack,
  input  logic             i_clear_overrun,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_valid,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_RECV} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic [WIDTH-1:0] r_sreg;
  logic [WIDTH-1:0] w_sreg_next;
  logic [WIDTH-1:0] w_shifted;
  logic             w_complete;
  logic [WIDTH-1:0] r_data_out;
  logic             r_valid;
  logic             r_overrun;

  // Both shift directions are formed so every shift-register bit has a reader.
  always_comb begin
    if (MSB_FIRST) w_shifted = {r_sreg[WIDTH-2:0], i_in};
    else           w_shifted = {i_in, r_sreg[WIDTH-1:1]};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sreg  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_sreg  <= w_sreg_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sreg_next  = r_sreg;
    w_complete   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_RECV;
          w_cnt_next   = '0;
          w_sreg_next  = '0;
        end
      end
      S_RECV: begin
        if (i_start) begin
          w_cnt_next  = '0;
          w_sreg_next = '0;
        end else if (i_shift) begin
          w_sreg_next = w_shifted;
          if (r_cnt == LAST_BIT) begin
            w_complete   = 1'b1;
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Completion takes priority over Ack; an Ack on the completion edge accepts the old word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_complete) begin
        r_data_out <= w_shifted;
        r_valid    <= 1'b1;
      end else if (i_ack && r_valid) begin
        r_valid <= 1'b0;
      end
      if (w_complete && r_valid && !i_ack) r_overrun <= 1'b1;
      else if (i_clear_overrun)            r_overrun <= 1'b0;
    end
  end

  assign o_data_out = r_data_out;
  assign o_valid    = r_valid;
  assign o_overrun  = r_overrun;
  assign o_busy     = (r_state == S_RECV);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: an MSB-first and an LSB-first instance
// share one stimulus stream; expected values are hand-computed constants.
module tb_serial_word_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sin = 1'b0;
  logic       shift = 1'b0;
  logic       start = 1'b0;
  logic       ack = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] dout_m, dout_l;
  logic       valid_m, valid_l, ovr_m, ovr_l, busy_m, busy_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_word_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_in(sin), .i_shift(shift), .i_start(start),
    .i_ack(ack), .i_clear_overrun(clr), .o_data_out(dout_m), .o_valid(valid_m),
    .o_overrun(ovr_m), .o_busy(busy_m)
  );

  serial_word_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_lsb (
    .i_clk(clk), .i_reset(rst), .i_in(sin), .i_shift(shift), .i_start(start),
    .i_ack(ack), .i_clear_overrun(clr), .o_data_out(dout_l), .o_valid(valid_l),
    .o_overrun(ovr_l), .o_busy(busy_l)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    sin   = b;
    shift = 1'b1;
    cyc();
    shift = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
  endtask

  logic [7:0] word;
  logic [7:0] tx;

  initial begin
    // T1: reset state, then a basic frame
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_data", dout_m, 8'h00);
    chk("rst_valid", valid_m, 1'b0);
    chk("rst_ovr", ovr_m, 1'b0);
    chk("rst_busy", busy_m, 1'b0);
    send_bit(1'b1);                       // Shift in IDLE is ignored
    chk("idle_shift", busy_m, 1'b0);
    do_start();
    chk("start_busy", busy_m, 1'b1);
    word = 8'hB2;
    for (int i = 7; i >= 1; i--) send_bit(word[i]);
    chk("t1_pre_valid", valid_m, 1'b0);
    chk("t1_pre_busy", busy_m, 1'b1);
    send_bit(word[0]);
    chk("t1_data", dout_m, 8'hB2);
    chk("t1_valid", valid_m, 1'b1);
    chk("t1_busy", busy_m, 1'b0);
    chk("t1_ovr", ovr_m, 1'b0);
    chk("t1_lsb_data", dout_l, 8'h4D);

    // T2: ack, then same stream with idle gaps carrying junk data
    do_ack();
    chk("t2_ack_valid", valid_m, 1'b0);
    chk("t2_ack_hold", dout_m, 8'hB2);
    do_start();
    for (int i = 7; i >= 0; i--) begin
      for (int g = 0; g < (i % 4); g++) begin
        sin = ~word[i];
        cyc();
      end
      send_bit(word[i]);
    end
    chk("t2_data", dout_m, 8'hB2);
    chk("t2_valid", valid_m, 1'b1);

    // T3: unacked word overwritten -> overrun
    do_start();
    send_word(8'h5A);
    chk("t3_data", dout_m, 8'h5A);
    chk("t3_valid", valid_m, 1'b1);
    chk("t3_ovr", ovr_m, 1'b1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("t3_clr_ovr", ovr_m, 1'b0);
    chk("t3_clr_valid", valid_m, 1'b1);

    // T4: Ack on the completion edge accepts the old word without overrun
    do_start();
    word = 8'h3C;
    for (int i = 7; i >= 1; i--) send_bit(word[i]);
    ack = 1'b1;
    send_bit(word[0]);
    ack = 1'b0;
    chk("t4_data", dout_m, 8'h3C);
    chk("t4_valid", valid_m, 1'b1);
    chk("t4_ovr", ovr_m, 1'b0);
    do_ack();
    chk("t4_ack_valid", valid_m, 1'b0);
    do_ack();
    chk("t4_ack2_valid", valid_m, 1'b0);
    chk("t4_ack2_data", dout_m, 8'h3C);

    // Overrun set and ClearOverrun on the same edge: set wins
    do_start();
    send_word(8'h11);
    do_start();
    word = 8'h22;
    for (int i = 7; i >= 1; i--) send_bit(word[i]);
    clr = 1'b1;
    send_bit(word[0]);
    clr = 1'b0;
    chk("set_wins_ovr", ovr_m, 1'b1);
    chk("set_wins_data", dout_m, 8'h22);
    clr = 1'b1;
    do_ack();
    clr = 1'b0;
    chk("clr2_ovr", ovr_m, 1'b0);

    // T5: restart mid-frame (Shift on the Start cycle ignored), then reset mid-frame
    do_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    start = 1'b1;
    shift = 1'b1;
    sin   = 1'b0;
    cyc();
    start = 1'b0;
    shift = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    chk("t5_pre_valid", valid_m, 1'b0);
    send_bit(1'b1);
    chk("t5_data", dout_m, 8'hFF);
    chk("t5_valid", valid_m, 1'b1);
    do_ack();
    do_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst = 1'b1;
    shift = 1'b1;
    cyc();
    rst = 1'b0;
    shift = 1'b0;
    chk("t5_rst_data", dout_m, 8'h00);
    chk("t5_rst_valid", valid_m, 1'b0);
    chk("t5_rst_busy", busy_m, 1'b0);
    chk("t5_rst_ovr", ovr_m, 1'b0);
    send_word(8'hA5);
    chk("t5_nostart_v", valid_m, 1'b0);
    chk("t5_nostart_d", dout_m, 8'h00);

    // T6: loopback from a parallel-load/serial-out transmitter loaded with C5
    tx = 8'hC5;
    do_start();
    for (int i = 0; i < 8; i++) begin
      send_bit(tx[7]);
      tx = {tx[6:0], 1'b0};
    end
    chk("t6_msb_data", dout_m, 8'hC5);
    chk("t6_lsb_data", dout_l, 8'hA3);
    chk("t6_lsb_valid", valid_l, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
